// File: rtl/zero_detect.sv
`default_nettype none
// ============================================================================
// Module      : zero_detect
// Description : Registered binary32 operand-B classifier (zero/inf/NaN,
//               subnormal flag) with a mantissa leading-zero count.
// Revision    : 1.0 - initial release
// ============================================================================
module zero_detect #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int LZC_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sign_B,
    input  logic [EXP_W-1:0]  exp_B,
    input  logic [MANT_W-1:0] mant_B,
    input  logic              in_valid,
    output logic [2:0]        special_B,
    output logic              denorm_B,
    output logic              sign_out_B,
    output logic [LZC_W-1:0]  lzc_B,
    output logic              out_valid
);

    localparam logic [LZC_W-1:0] c_ZERO_MANT_LZC = LZC_W'(MANT_W);

    logic             w_exp_zero;
    logic             w_exp_ones;
    logic             w_mant_zero;
    logic [2:0]       w_special;
    logic             w_denorm;
    logic [LZC_W-1:0] w_lzc;

    logic [2:0]       r_special;
    logic             r_denorm;
    logic             r_sign;
    logic [LZC_W-1:0] r_lzc;
    logic             r_valid;

    assign w_exp_zero  = ~|exp_B;
    assign w_exp_ones  = &exp_B;
    assign w_mant_zero = ~|mant_B;

    // Class code is one-hot {nan, inf, zero}, or all-zero for normal/subnormal
    assign w_special = {w_exp_ones & ~w_mant_zero,
                        w_exp_ones &  w_mant_zero,
                        w_exp_zero &  w_mant_zero};
    assign w_denorm  = w_exp_zero & ~w_mant_zero;

    // Ascending scan so the highest set bit is the last (winning) assignment
    always_comb begin
        w_lzc = c_ZERO_MANT_LZC;
        for (int i = 0; i < MANT_W; i++) begin
            if (mant_B[i]) begin
                w_lzc = LZC_W'(MANT_W - 1 - i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_special <= 3'b000;
            r_denorm  <= 1'b0;
            r_sign    <= 1'b0;
            r_lzc     <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_special <= w_special;
            r_denorm  <= w_denorm;
            r_sign    <= sign_B;
            r_lzc     <= w_lzc;
            r_valid   <= in_valid;
        end
    end

    assign special_B  = r_special;
    assign denorm_B   = r_denorm;
    assign sign_out_B = r_sign;
    assign lzc_B      = r_lzc;
    assign out_valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_zero_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_zero_detect
// Description : Directed self-checking bench for zero_detect.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zero_detect;

    logic        clk;
    logic        rst_n;
    logic        sign_B;
    logic [7:0]  exp_B;
    logic [22:0] mant_B;
    logic        in_valid;
    logic [2:0]  special_B;
    logic        denorm_B;
    logic        sign_out_B;
    logic [4:0]  lzc_B;
    logic        out_valid;

    int n_vec;
    int n_bad;

    zero_detect #(
        .EXP_W  (8),
        .MANT_W (23),
        .LZC_W  (5)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sign_B     (sign_B),
        .exp_B      (exp_B),
        .mant_B     (mant_B),
        .in_valid   (in_valid),
        .special_B  (special_B),
        .denorm_B   (denorm_B),
        .sign_out_B (sign_out_B),
        .lzc_B      (lzc_B),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] sp, input logic dn,
                             input logic sg, input logic [4:0] lz, input logic vl);
        check({tag, ".special"}, 32'(special_B), 32'(sp));
        check({tag, ".denorm"},  32'(denorm_B),  32'(dn));
        check({tag, ".sign"},    32'(sign_out_B), 32'(sg));
        check({tag, ".lzc"},     32'(lzc_B),     32'(lz));
        check({tag, ".valid"},   32'(out_valid), 32'(vl));
    endtask

    // Drive at the falling edge, then sample 1 time unit after the next rise
    task automatic apply(input logic s, input logic [7:0] e, input logic [22:0] m, input logic v);
        @(negedge clk);
        sign_B   = s;
        exp_B    = e;
        mant_B   = m;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        sign_B   = 1'b1;
        exp_B    = 8'h00;
        mant_B   = 23'h0;
        in_valid = 1'b0;

        #22;
        check_all("reset_hold", 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("first_after_reset", 3'b001, 1'b0, 1'b1, 5'd23, 1'b0);

        apply(1'b0, 8'h81, 23'b10111001100110011001101, 1'b1);
        check_all("normal_6p9", 3'b000, 1'b0, 1'b0, 5'd0, 1'b1);

        apply(1'b0, 8'h00, 23'b10111001100110011001101, 1'b1);
        check_all("denorm_msb", 3'b000, 1'b1, 1'b0, 5'd0, 1'b1);

        apply(1'b0, 8'h00, 23'h000001, 1'b1);
        check_all("denorm_lsb", 3'b000, 1'b1, 1'b0, 5'd22, 1'b1);

        apply(1'b1, 8'h00, 23'h000100, 1'b1);
        check_all("denorm_bit8", 3'b000, 1'b1, 1'b1, 5'd14, 1'b1);

        apply(1'b0, 8'h7F, 23'h200000, 1'b0);
        check_all("normal_novalid", 3'b000, 1'b0, 1'b0, 5'd1, 1'b0);

        apply(1'b1, 8'h00, 23'h0, 1'b1);
        check_all("neg_zero", 3'b001, 1'b0, 1'b1, 5'd23, 1'b1);

        apply(1'b0, 8'h00, 23'h0, 1'b1);
        check_all("pos_zero", 3'b001, 1'b0, 1'b0, 5'd23, 1'b1);

        apply(1'b0, 8'hFF, 23'h0, 1'b1);
        check_all("inf", 3'b010, 1'b0, 1'b0, 5'd23, 1'b1);

        apply(1'b1, 8'hFF, 23'h400000, 1'b1);
        check_all("qnan", 3'b100, 1'b0, 1'b1, 5'd0, 1'b1);

        apply(1'b0, 8'hFF, 23'h000001, 1'b1);
        check_all("snan", 3'b100, 1'b0, 1'b0, 5'd22, 1'b1);

        apply(1'b0, 8'hFE, 23'h7FFFFF, 1'b1);
        check_all("max_normal", 3'b000, 1'b0, 1'b0, 5'd0, 1'b1);

        // Input change between edges must not reach the outputs
        @(negedge clk);
        exp_B = 8'hFF;
        mant_B = 23'h0;
        #2;
        check_all("no_comb_path", 3'b000, 1'b0, 1'b0, 5'd0, 1'b1);

        apply(1'b1, 8'hFF, 23'h123456, 1'b1);
        check_all("nan_pre_reset", 3'b100, 1'b0, 1'b1, 5'd2, 1'b1);

        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);

        @(posedge clk);
        #1;
        check_all("reset_over_edge", 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);

        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check_all("release_novalid", 3'b100, 1'b0, 1'b1, 5'd2, 1'b0);

        apply(1'b0, 8'h40, 23'h000800, 1'b1);
        check_all("release_valid", 3'b000, 1'b0, 1'b0, 5'd11, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
